// File: rtl/alu_rv_pipe.sv
// alu_rv_pipe: two-stage valid/ready ALU.
// S1 holds the operands, S2 holds the result.
// An error counter tracks delivered results that carry the error flag.
module alu_rv_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ECNT_W = 8
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_VALID,
  output logic              o_READY,
  input  logic [1:0]        i_OP,
  input  logic [WIDTH-1:0]  i_A,
  input  logic [WIDTH-1:0]  i_B,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic [WIDTH-1:0]  o_Y,
  output logic              o_OVERFLOW,
  output logic              o_ERR,
  input  logic              i_CLR,
  output logic [ECNT_W-1:0] o_ERR_CNT
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned Y_MAX = (1 << WIDTH) - 1;
  localparam logic [ECNT_W-1:0] ECNT_MAX = {ECNT_W{1'b1}};

  localparam logic [1:0] OP_SUB  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_LO   = 2'b10;
  localparam logic [1:0] OP_OH   = 2'b11;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             ovf;
    logic             err;
  } res_t;

  // Pipeline state: two independent valid bits, no encoded FSM
  logic s1_vld;
  s1_t  s1_q;
  logic s2_vld;

  // Handshake terms
  logic in_xfer_c;
  logic out_xfer_c;
  logic s2_load_c;

  // Datapath terms
  logic [DW-1:0]    cat_c;
  logic [WIDTH-1:0] diff_c;
  logic [DW-1:0]    lo_vec_c;
  logic             lo_run_c;
  int unsigned      lo_cnt_c;
  logic [DW-1:0]    oh_vec_c;
  logic             oh_found_c;
  int unsigned      oh_idx_c;
  int unsigned      oh_ones_c;
  res_t             sub_res_c;
  res_t             nand_res_c;
  res_t             lo_res_c;
  res_t             oh_res_c;
  res_t             res_c;

  assign o_VALID = s2_vld;

  // Handshake: S2 frees on output transfer, S1 frees when it moves into S2
  always_comb begin
    out_xfer_c = s2_vld & i_READY;
    s2_load_c  = s1_vld & (~s2_vld | out_xfer_c);
    o_READY    = ~s1_vld | s2_load_c;
    in_xfer_c  = i_VALID & o_READY;
  end

  // Signed subtract with two's-complement overflow
  always_comb begin
    cat_c         = {s1_q.b, s1_q.a};
    diff_c        = s1_q.a - s1_q.b;
    sub_res_c.y   = diff_c;
    sub_res_c.ovf = (s1_q.a[WIDTH-1] != s1_q.b[WIDTH-1]) &
                    (s1_q.a[WIDTH-1] != diff_c[WIDTH-1]);
    sub_res_c.err = 1'b0;
  end

  // Bitwise nand
  always_comb begin
    nand_res_c.y   = ~(s1_q.a & s1_q.b);
    nand_res_c.ovf = 1'b0;
    nand_res_c.err = 1'b0;
  end

  // Leading-ones count of {B,A}, scanning from the MSB via left shifts
  always_comb begin
    lo_vec_c = cat_c;
    lo_run_c = 1'b1;
    lo_cnt_c = 0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (lo_run_c && lo_vec_c[DW-1]) begin
        lo_cnt_c = lo_cnt_c + 1;
      end else begin
        lo_run_c = 1'b0;
      end
      lo_vec_c = lo_vec_c << 1;
    end
    lo_res_c.y   = WIDTH'(lo_cnt_c);
    lo_res_c.ovf = (lo_cnt_c > Y_MAX);
    lo_res_c.err = 1'b0;
  end

  // One-hot decode of {B,A}: lowest set index, error unless exactly one bit
  always_comb begin
    oh_vec_c   = cat_c;
    oh_found_c = 1'b0;
    oh_idx_c   = 0;
    oh_ones_c  = 0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (oh_vec_c[0]) begin
        oh_ones_c = oh_ones_c + 1;
        if (!oh_found_c) begin
          oh_found_c = 1'b1;
          oh_idx_c   = i;
        end
      end
      oh_vec_c = oh_vec_c >> 1;
    end
    oh_res_c.y   = WIDTH'(oh_idx_c);
    oh_res_c.ovf = (oh_idx_c > Y_MAX);
    oh_res_c.err = (oh_ones_c != 1);
  end

  // Operation select for the S2 load
  always_comb begin
    res_c = sub_res_c;
    case (s1_q.op)
      OP_SUB:  res_c = sub_res_c;
      OP_NAND: res_c = nand_res_c;
      OP_LO:   res_c = lo_res_c;
      OP_OH:   res_c = oh_res_c;
      default: res_c = sub_res_c;
    endcase
  end

  // S1 operand stage
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else if (in_xfer_c) begin
      s1_vld <= 1'b1;
      s1_q   <= {i_OP, i_A, i_B};
    end else if (s2_load_c) begin
      s1_vld <= 1'b0;
    end
  end

  // S2 result stage; holds its contents while the output is stalled
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      s2_vld     <= 1'b0;
      o_Y        <= '0;
      o_OVERFLOW <= 1'b0;
      o_ERR      <= 1'b0;
    end else if (s2_load_c) begin
      s2_vld     <= 1'b1;
      o_Y        <= res_c.y;
      o_OVERFLOW <= res_c.ovf;
      o_ERR      <= res_c.err;
    end else if (out_xfer_c) begin
      s2_vld     <= 1'b0;
    end
  end

  // Saturating count of delivered error results; clear wins over increment
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_ERR_CNT <= '0;
    end else if (i_CLR) begin
      o_ERR_CNT <= '0;
    end else if (out_xfer_c && o_ERR && (o_ERR_CNT != ECNT_MAX)) begin
      o_ERR_CNT <= o_ERR_CNT + ECNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_rv_pipe.sv
// tb_alu_rv_pipe: directed and randomized bench for alu_rv_pipe.
// Expected results come from an arithmetic model and an in-order queue.
module tb_alu_rv_pipe;

  localparam int unsigned W  = 4;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ivalid;
  logic          oready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ovalid;
  logic          iready;
  logic [W-1:0]  y;
  logic          ovf;
  logic          err;
  logic          clr;
  logic [EW-1:0] ecnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [W-1:0] y;
    logic         ovf;
    logic         err;
  } res_t;

  res_t        expq[$];
  res_t        mon_e;
  res_t        held;
  bit          held_vld;
  bit          prev_in;
  int unsigned m_ecnt;
  int          acc_cnt;
  int          occ;

  always #5 clk = ~clk;

  alu_rv_pipe #(.WIDTH(W), .ECNT_W(EW)) dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_VALID    (ivalid),
    .o_READY    (oready),
    .i_OP       (op),
    .i_A        (a),
    .i_B        (b),
    .o_VALID    (ovalid),
    .i_READY    (iready),
    .o_Y        (y),
    .o_OVERFLOW (ovf),
    .o_ERR      (err),
    .i_CLR      (clr),
    .o_ERR_CNT  (ecnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: results straight from the arithmetic definition of each op
  function automatic res_t model(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    res_t r;
    int   md, sa, sb, d, cat, cnt, idx, k;
    md  = 1 << W;
    cat = int'(bb) * md + int'(aa);
    r   = '0;
    case (o)
      2'd0: begin
        sa = int'(aa); if (sa >= md / 2) sa = sa - md;
        sb = int'(bb); if (sb >= md / 2) sb = sb - md;
        d  = sa - sb;
        r.y   = W'(((d % md) + md) % md);
        r.ovf = (d < -(md / 2)) || (d > md / 2 - 1);
      end
      2'd1: r.y = ~(aa & bb);
      2'd2: begin
        cnt = 0;
        k   = 2 * W - 1;
        while (k >= 0 && ((cat >> k) & 1) == 1) begin cnt++; k--; end
        r.y   = W'(cnt % md);
        r.ovf = cnt > md - 1;
      end
      default: begin
        if (cat != 0) begin
          idx = 0;
          while (((cat >> idx) & 1) == 0) idx++;
          r.y   = W'(idx % md);
          r.ovf = idx > md - 1;
        end
        r.err = ($countones(cat) != 1);
      end
    endcase
    return r;
  endfunction

  // Compare process: cycle-level checks against the queue model
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", 32'(ovalid), 0);
      expq.delete();
      m_ecnt   = 0;
      prev_in  = 0;
      held_vld = 0;
    end else begin
      occ = expq.size();
      check("ready", 32'(oready), 32'((occ < 2) || iready));
      check("valid", 32'(ovalid), 32'((occ > 0) && !(occ == 1 && prev_in)));
      if (held_vld) check("stall_hold", 32'({y, ovf, err}), 32'(held));
      check("err_cnt", 32'(ecnt), m_ecnt);
      mon_e = '0;
      if (ovalid && iready) begin
        if (expq.size() == 0) check("result_present", 0, 1);
        else begin
          mon_e = expq.pop_front();
          check("result", 32'({y, ovf, err}), 32'(mon_e));
        end
      end
      if (clr) m_ecnt = 0;
      else if (ovalid && iready && mon_e.err && m_ecnt < (1 << EW) - 1) m_ecnt++;
      held_vld = ovalid && !iready;
      held     = {y, ovf, err};
      if (ivalid && oready) begin
        expq.push_back(model(op, a, b));
        prev_in = 1;
        acc_cnt++;
      end else begin
        prev_in = 0;
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    int guard;
    guard  = 0;
    op     = o;
    a      = aa;
    b      = bb;
    ivalid = 1'b1;
    @(negedge clk);
    while (!oready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!oready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    ivalid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    logic [2*W-1:0] cat;
    rst = 1'b1; ivalid = 1'b0; iready = 1'b1; clr = 1'b0;
    op = '0; a = '0; b = '0; acc_cnt = 0;
    #1;
    check("reset_valid", 32'(ovalid), 0);
    check("reset_ready", 32'(oready), 1);
    check("reset_out", 32'({y, ovf, err}), 0);
    check("reset_cnt", 32'(ecnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Model pinned to hand-computed values
    check("pin_sub", 32'(model(2'd0, 4'h7, 4'hF)), 32'({4'h8, 1'b1, 1'b0}));
    check("pin_sub2", 32'(model(2'd0, 4'h8, 4'h1)), 32'({4'h7, 1'b1, 1'b0}));
    check("pin_nand", 32'(model(2'd1, 4'hC, 4'hA)), 32'({4'h7, 1'b0, 1'b0}));
    check("pin_lo", 32'(model(2'd2, 4'hC, 4'hF)), 32'({4'h6, 1'b0, 1'b0}));
    check("pin_lo8", 32'(model(2'd2, 4'hF, 4'hF)), 32'({4'h8, 1'b0, 1'b0}));
    check("pin_oh", 32'(model(2'd3, 4'h4, 4'h0)), 32'({4'h2, 1'b0, 1'b0}));
    check("pin_oh2", 32'(model(2'd3, 4'h1, 4'h1)), 32'({4'h0, 1'b0, 1'b1}));
    check("pin_oh0", 32'(model(2'd3, 4'h0, 4'h0)), 32'({4'h0, 1'b0, 1'b1}));

    // Subtract overflow, two-edge latency
    tick(2);
    send(2'd0, 4'h7, 4'hF);
    check("sub_lat_valid_early", 32'(ovalid), 0);
    tick(1);
    check("sub_valid", 32'(ovalid), 1);
    check("sub_out", 32'({y, ovf, err}), 32'({4'h8, 1'b1, 1'b0}));

    // Nand then leading-ones back to back
    tick(2);
    send(2'd1, 4'hC, 4'hA);
    send(2'd2, 4'hC, 4'hF);
    check("nand_out", 32'({ovalid, y}), 32'({1'b1, 4'h7}));
    tick(1);
    check("lo_out", 32'({ovalid, y, ovf}), 32'({1'b1, 4'h6, 1'b0}));

    // One-hot decode cases
    tick(2);
    send(2'd3, 4'h4, 4'h0);
    send(2'd3, 4'h1, 4'h1);
    check("oh_one", 32'({y, err}), 32'({4'h2, 1'b0}));
    send(2'd3, 4'h0, 4'h0);
    check("oh_two", 32'({y, err}), 32'({4'h0, 1'b1}));
    tick(1);
    check("oh_cnt", 32'(ecnt), 1);
    check("oh_zero", 32'({y, ovf, err}), 32'({4'h0, 1'b0, 1'b1}));

    // Backpressure: five words against a four-cycle stall
    tick(3);
    iready = 1'b0;
    g = acc_cnt;
    fork
      begin
        for (int k = 0; k < 5; k++) send(2'd0, W'(k + 1), 4'h0);
      end
      begin
        tick(4);
        check("bp_ready_low", 32'(oready), 0);
        check("bp_accepted", 32'(acc_cnt - g), 2);
        check("bp_held_y", 32'({ovalid, y}), 32'({1'b1, 4'h1}));
        iready = 1'b1;
      end
    join
    tick(4);
    check("bp_all_out", 32'(expq.size()), 0);

    // Reset with both stages full
    iready = 1'b0;
    send(2'd3, 4'h3, 4'h0);
    send(2'd1, 4'h5, 4'h6);
    check("full_ready", 32'(oready), 0);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(ovalid), 0);
    check("rst_mid_cnt", 32'(ecnt), 0);
    check("rst_mid_ready", 32'(oready), 1);
    tick(1);
    rst = 1'b0;
    iready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale", 32'(ovalid), 0);
    end
    @(posedge clk); #1;
    send(2'd1, 4'h0, 4'h0);
    tick(1);
    check("post_rst_word", 32'({ovalid, y}), 32'({1'b1, 4'hF}));

    // Counter saturation, then clear beating an increment
    for (int k = 0; k < 260; k++) send(2'd3, 4'h0, 4'h0);
    tick(3);
    check("sat_cnt", 32'(ecnt), 255);
    iready = 1'b0;
    send(2'd3, 4'h3, 4'h0);
    g = 0;
    while (!ovalid && g < 10) begin tick(1); g++; end
    check("clr_word_valid", 32'(ovalid), 1);
    clr = 1'b1;
    iready = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_cnt", 32'(ecnt), 0);

    // Randomized traffic with stalls, clears and occasional resets
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      rst    = ($urandom_range(0, 399) == 0);
      ivalid = ($urandom_range(0, 3) != 0);
      iready = ($urandom_range(0, 9) < 7);
      clr    = ($urandom_range(0, 49) == 0);
      op     = 2'($urandom_range(0, 3));
      a      = W'($urandom);
      b      = W'($urandom);
      if (op == 2'd3 && $urandom_range(0, 1) == 1) begin
        cat = (2*W)'(1) << $urandom_range(0, 2 * W - 1);
        {b, a} = cat;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; ivalid = 1'b0; iready = 1'b1; clr = 1'b0;
    tick(5);
    check("drain_empty", 32'(expq.size()), 0);
    check("drain_valid", 32'(ovalid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_rv_pipe.md
ALU_RV_PIPE -- requirements
Module: alu_rv_pipe

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits, legal range 2..16.
REQ-002 Parameter ECNT_W, default 8, width of the error counter.
REQ-003 i_CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 i_RST  input  1  reset, asynchronous and active-high.
REQ-005 i_VALID  input  1  upstream operand-valid.
REQ-006 o_READY  output  1  block can accept an operand this cycle.
REQ-007 i_OP  input  2  operation: 00 subtract, 01 nand, 10 leading-ones, 11 one-hot decode.
REQ-008 i_A, i_B  input  WIDTH each  operands; signed two's complement for subtract.
REQ-009 o_VALID  output  1  result-valid.
REQ-010 i_READY  input  1  downstream result-ready.
REQ-011 o_Y  output  WIDTH  result.
REQ-012 o_OVERFLOW  output  1  result overflow flag.
REQ-013 o_ERR  output  1  result error flag.
REQ-014 i_CLR  input  1  synchronous error-counter clear.
REQ-015 o_ERR_CNT  output  ECNT_W  saturating count of delivered results with o_ERR=1.

Function
REQ-016 The transfer rules SHALL be:
- Input transfer: i_VALID & o_READY.
- Output transfer: o_VALID & i_READY.
REQ-017 The block SHALL be a two-stage pipeline:
- S1 registers i_OP/i_A/i_B with a valid bit.
- S2 registers o_Y/o_OVERFLOW/o_ERR with a valid bit.
- o_VALID is the S2 valid bit.
REQ-018 S2 SHALL load from S1 when S1 is valid and (S2 is empty or an output transfer occurs).
REQ-019 S1 SHALL load on an input transfer; S1 valid clears when S1 moves to S2 without a new input.
REQ-020 o_READY SHALL equal (S1 empty) or (S1 moves to S2 this cycle); it is combinational from i_READY.
REQ-021 Latency SHALL be 2 cycles: a word accepted at edge N appears on o_VALID after edge N+1, with throughput 1 word/cycle when i_READY=1.
REQ-022 Under backpressure, S2 SHALL hold o_Y/o_OVERFLOW/o_ERR stable and o_VALID high until transfer; no word may be lost, duplicated or reordered.
REQ-023 Subtract SHALL compute Y=A-B mod 2^WIDTH, with OVERFLOW=(A[msb]!=B[msb])&(A[msb]!=Y[msb]) and ERR=0.
REQ-024 Nand SHALL compute Y=~(A&B) bitwise, with OVERFLOW=0 and ERR=0.
REQ-025 Leading-ones SHALL count consecutive 1s of {B,A} from bit 2*WIDTH-1 downward, stopping at the first 0 (count 0..2*WIDTH):
- Y = count mod 2^WIDTH.
- OVERFLOW = count>2^WIDTH-1.
- ERR = 0.
REQ-026 One-hot decode SHALL operate on {B,A}:
- Y = index of the lowest set bit (mod 2^WIDTH).
- OVERFLOW = index>2^WIDTH-1.
- ERR = 1 if zero bits or more than one bit is set; all-zero input gives Y=0, OVERFLOW=0.
REQ-027 o_ERR_CNT SHALL increment by 1 on each output transfer with o_ERR=1 and saturate at 2^ECNT_W-1.
REQ-028 i_CLR SHALL zero o_ERR_CNT on the next edge and take priority over a simultaneous increment.
REQ-029 Illegal or unknown state SHALL NOT exist: both valid bits are independent flops with no encoded FSM beyond them.

Reset
REQ-030 On i_RST=1, the following SHALL clear immediately, independent of i_CLK:
- both valid bits, o_Y, o_OVERFLOW, o_ERR and o_ERR_CNT go to 0.
- o_READY goes to 1.
REQ-031 Reset asserted mid-transfer SHALL discard all in-flight words; the first edge after release accepts new input normally.

Verification (WIDTH=4, ECNT_W=8)
REQ-032 Subtract overflow: OP=00, A=0111, B=1111 -> two edges later o_VALID=1, Y=1000, OVERFLOW=1, ERR=0.
REQ-033 Nand and leading-ones, issued back-to-back:
- OP=01, A=1100, B=1010 -> Y=0111.
- OP=10, B=1111, A=1100 -> Y=0110, OVERFLOW=0, on the following cycle.
REQ-034 One-hot decode:
- OP=11, B=0000, A=0100 -> Y=0010, ERR=0.
- B=0001, A=0001 -> Y=0000, ERR=1, o_ERR_CNT=1 after transfer.
- B=0000, A=0000 -> ERR=1.
REQ-035 Backpressure: stream 5 words with i_VALID=1 and hold i_READY=0 for 4 cycles:
- o_READY falls after 2 words are accepted.
- o_Y is stable throughout the stall.
- On release, all 5 results appear in order with none lost.
REQ-036 Reset mid-operation: assert i_RST with both stages full -> o_VALID=0, o_ERR_CNT=0 immediately; no stale result emerges after release.
REQ-037 Counter saturation and clear:
- 260 error transfers -> o_ERR_CNT=255.
- i_CLR together with an error transfer -> o_ERR_CNT=0.
